// File: rtl/unidade_controle_pkg.sv
// Shared types and encodings for the multicycle control unit of the RV64I-subset datapath.
package unidade_controle_pkg;

    localparam int unsigned BITS = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned OPW  = 7;
    localparam int unsigned F3W  = 3;
    localparam int unsigned F7W  = 7;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        ERRO
    } state_e;

    typedef enum logic [2:0] {
        K_ILEGAL,
        K_ADD,
        K_SUB,
        K_ADDI,
        K_LD,
        K_SD,
        K_BR
    } classe_e;

    localparam logic [OPW-1:0] OP_R  = 7'b0110011;
    localparam logic [OPW-1:0] OP_I  = 7'b0010011;
    localparam logic [OPW-1:0] OP_LD = 7'b0000011;
    localparam logic [OPW-1:0] OP_SD = 7'b0100011;
    localparam logic [OPW-1:0] OP_B  = 7'b1100011;

    localparam logic [F3W-1:0] F3_ADD  = 3'b000;
    localparam logic [F3W-1:0] F3_DW   = 3'b011;
    localparam logic [F3W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3W-1:0] F3_BNE  = 3'b001;
    localparam logic [F3W-1:0] F3_BLT  = 3'b100;
    localparam logic [F3W-1:0] F3_BGE  = 3'b101;
    localparam logic [F3W-1:0] F3_BLTU = 3'b110;
    localparam logic [F3W-1:0] F3_BGEU = 3'b111;

    localparam logic [F7W-1:0] F7_ADD = 7'b0000000;
    localparam logic [F7W-1:0] F7_SUB = 7'b0100000;

    typedef struct packed {
        logic [F7W-1:0] funct7;
        logic [F3W-1:0] funct3;
        logic [OPW-1:0] opcode;
    } campos_t;

    // Maps latched decode fields to an instruction class; unsupported encodings are K_ILEGAL.
    function automatic classe_e classifica(campos_t c);
        classe_e k;
        k = K_ILEGAL;
        case (c.opcode)
            OP_R: begin
                if (c.funct3 == F3_ADD && c.funct7 == F7_ADD) k = K_ADD;
                else if (c.funct3 == F3_ADD && c.funct7 == F7_SUB) k = K_SUB;
            end
            OP_I:  if (c.funct3 == F3_ADD) k = K_ADDI;
            OP_LD: if (c.funct3 == F3_DW) k = K_LD;
            OP_SD: if (c.funct3 == F3_DW) k = K_SD;
            OP_B:  if (c.funct3 != 3'b010 && c.funct3 != 3'b011) k = K_BR;
            default: k = K_ILEGAL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Control-unit bundle: memory handshakes, ULA flags/controls and datapath strobes.
interface unidade_controle_if;
    import unidade_controle_pkg::*;

    logic [ILEN-1:0] instr;
    logic            imem_req;
    logic            imem_ready;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ready;
    logic            flag_maior_u;
    logic            flag_igual;
    logic            flag_menor;
    logic            soma_ou_subtrai;
    logic            subtraindo;
    logic            imediato;
    logic            load_ir;
    logic            load_pc;
    logic            pc_sel;
    logic            reg_write;
    logic            wb_sel;
    logic            erro;
    logic [BITS-1:0] instret;

    modport master (
        input  instr, imem_ready, dmem_ready, flag_maior_u, flag_igual, flag_menor,
        output imem_req, dmem_req, dmem_we, soma_ou_subtrai, subtraindo, imediato,
               load_ir, load_pc, pc_sel, reg_write, wb_sel, erro, instret
    );

    modport slave (
        output instr, imem_ready, dmem_ready, flag_maior_u, flag_igual, flag_menor,
        input  imem_req, dmem_req, dmem_we, soma_ou_subtrai, subtraindo, imediato,
               load_ir, load_pc, pc_sel, reg_write, wb_sel, erro, instret
    );
endinterface

// File: rtl/unidade_controle_decodificador_desvio.sv
// Branch resolution: funct3 plus the ULA comparison flags give the taken decision.
module decodificador_desvio
    import unidade_controle_pkg::*;
(
    input  logic [F3W-1:0] funct3,
    input  logic           flag_maior_u,
    input  logic           flag_igual,
    input  logic           flag_menor,
    output logic           taken_c
);
    always_comb begin
        taken_c = 1'b0;
        case (funct3)
            F3_BEQ:  taken_c = flag_igual;
            F3_BNE:  taken_c = !flag_igual;
            F3_BLT:  taken_c = flag_menor;
            F3_BGE:  taken_c = !flag_menor;
            F3_BLTU: taken_c = !flag_igual && !flag_maior_u;
            F3_BGEU: taken_c = flag_maior_u || flag_igual;
            default: taken_c = 1'b0;
        endcase
    end
endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit: fetch/decode/exec/mem/wb sequencing with retired-instruction count.
module unidade_controle
    import unidade_controle_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    unidade_controle_if.master bus
);
    state_e          state_q, state_d;
    campos_t         campos_q;
    classe_e         classe_c;
    logic            taken_c;
    logic            soma_c, sub_c, imed_c;
    logic            imem_req_c, load_ir_c, dmem_req_c, dmem_we_c;
    logic            ula_soma_c, ula_sub_c, ula_imed_c;
    logic            load_pc_c, pc_sel_c, reg_write_c, wb_sel_c, erro_c;
    logic [BITS-1:0] instret_q;

    assign classe_c = classifica(campos_q);
    assign soma_c   = classe_c inside {K_ADD, K_SUB, K_ADDI, K_LD, K_SD};
    assign sub_c    = (classe_c == K_SUB);
    assign imed_c   = classe_c inside {K_ADDI, K_LD, K_SD};

    decodificador_desvio u_desvio (
        .funct3       (campos_q.funct3),
        .flag_maior_u (bus.flag_maior_u),
        .flag_igual   (bus.flag_igual),
        .flag_menor   (bus.flag_menor),
        .taken_c      (taken_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Decode fields are captured on the accepted fetch only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 campos_q <= '0;
        else if (state_q == FETCH && bus.imem_ready) campos_q <= {bus.instr[31:25], bus.instr[14:12], bus.instr[6:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         instret_q <= '0;
        else if (load_pc_c) instret_q <= instret_q + BITS'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (bus.imem_ready) state_d = DECODE;
            DECODE:  state_d = (classe_c == K_ILEGAL) ? ERRO : EXEC;
            EXEC: begin
                if (classe_c == K_BR)                           state_d = FETCH;
                else if (classe_c == K_LD || classe_c == K_SD) state_d = MEM;
                else                                            state_d = WB;
            end
            MEM:     if (bus.dmem_ready) state_d = (classe_c == K_LD) ? WB : FETCH;
            WB:      state_d = FETCH;
            ERRO:    state_d = ERRO;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs; load_ir, branch pc_sel and SD retire peek at live inputs.
    always_comb begin
        imem_req_c  = 1'b0;
        load_ir_c   = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        ula_soma_c  = 1'b0;
        ula_sub_c   = 1'b0;
        ula_imed_c  = 1'b0;
        load_pc_c   = 1'b0;
        pc_sel_c    = 1'b0;
        reg_write_c = 1'b0;
        wb_sel_c    = 1'b0;
        erro_c      = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                load_ir_c  = bus.imem_ready;
            end
            EXEC: begin
                ula_soma_c = soma_c;
                ula_sub_c  = sub_c;
                ula_imed_c = imed_c;
                if (classe_c == K_BR) begin
                    load_pc_c = 1'b1;
                    pc_sel_c  = taken_c;
                end
            end
            MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (classe_c == K_SD);
                ula_soma_c = soma_c;
                ula_sub_c  = sub_c;
                ula_imed_c = imed_c;
                load_pc_c  = (classe_c == K_SD) && bus.dmem_ready;
            end
            WB: begin
                reg_write_c = 1'b1;
                load_pc_c   = 1'b1;
                wb_sel_c    = (classe_c == K_LD);
                if (classe_c != K_LD) begin
                    ula_soma_c = soma_c;
                    ula_sub_c  = sub_c;
                    ula_imed_c = imed_c;
                end
            end
            ERRO:    erro_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.imem_req        = imem_req_c;
    assign bus.load_ir         = load_ir_c;
    assign bus.dmem_req        = dmem_req_c;
    assign bus.dmem_we         = dmem_we_c;
    assign bus.soma_ou_subtrai = ula_soma_c;
    assign bus.subtraindo      = ula_sub_c;
    assign bus.imediato        = ula_imed_c;
    assign bus.load_pc         = load_pc_c;
    assign bus.pc_sel          = pc_sel_c;
    assign bus.reg_write       = reg_write_c;
    assign bus.wb_sel          = wb_sel_c;
    assign bus.erro            = erro_c;
    assign bus.instret         = instret_q;
endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit that drives the ULA's control inputs, consumes its three comparison flags, and sequences the RV64I subset the datapath supports: ADD, SUB, ADDI, LD, SD and the six conditional branches. It sits beside the datapath, latches each fetched instruction's decode fields, and steps through fetch, decode, execute, memory and writeback. It handshakes with instruction and data memory and counts retired instructions.

## Interface

- BITS, 64, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- instr  in  32  instruction word from instruction memory, valid when imem_ready=1
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  instruction memory done; instr valid this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable (SD), qualified by dmem_req
- dmem_ready  in  1  data memory done
- flag_maior_u, flag_igual, flag_menor  in  1 each  ULA flags: A>B unsigned, A==B, A<B signed
- soma_ou_subtrai, subtraindo, imediato  out  1 each  ULA controls
- load_ir  out  1  datapath latches instr into its IR
- load_pc  out  1  datapath updates PC this cycle
- pc_sel  out  1  0: PC+4, 1: PC+imm_B (qualified by load_pc)
- reg_write  out  1  register file write
- wb_sel  out  1  0: ULA dout, 1: memory read data
- erro  out  1  sticky illegal-instruction indicator
- instret  out  BITS  retired-instruction count

## Operation

- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERRO.
- IDLE: entered only from reset; all outputs 0; next is FETCH.
- FETCH: imem_req=1. If imem_ready=1, then load_ir=1, opcode/funct3/funct7 latch internally, and next is DECODE. Otherwise the FSM stays in FETCH.
- DECODE: the latched fields are classified.
  - Legal: opcode 0110011 with funct3=000 and funct7 0000000 (ADD) or 0100000 (SUB); 0010011 with funct3=000 (ADDI); 0000011 with funct3=011 (LD); 0100011 with funct3=011 (SD); 1100011 with funct3 in {000,001,100,101,110,111}.
  - Anything else goes to ERRO. Legal instructions go to EXEC.
- EXEC: the ULA is driven.
  - ADD/ADDI/LD/SD: soma_ou_subtrai=1, subtraindo=0.
  - SUB: soma_ou_subtrai=1, subtraindo=1.
  - imediato=1 for ADDI, LD and SD; 0 otherwise.
  - Branch: soma_ou_subtrai=0, imediato=0, load_pc=1, pc_sel=taken, instruction retires, next is FETCH.
  - ADD/SUB/ADDI go to WB. LD/SD go to MEM.
- Branch taken rule, evaluated combinationally from the flags in EXEC:
  - BEQ: igual.
  - BNE: !igual.
  - BLT: menor.
  - BGE: !menor.
  - BLTU: !igual & !maior_u.
  - BGEU: maior_u | igual.
- MEM: dmem_req=1, dmem_we=1 for SD. ULA controls are held as in EXEC so the address stays stable. The FSM waits for dmem_ready.
  - On dmem_ready, LD goes to WB.
  - On dmem_ready, SD asserts load_pc=1, pc_sel=0, retires, and goes to FETCH.
- WB: reg_write=1 and load_pc=1 with pc_sel=0. wb_sel=1 for LD, else 0. ULA controls are held for ADD/SUB/ADDI. Retires; next is FETCH.
- ERRO: erro=1; all other outputs 0. No exit except reset.
- instret increments by 1 on every cycle with load_pc=1. It wraps from all-ones to 0.
- Outputs are Moore-decoded from the state and latched fields. The only exceptions are load_ir (uses imem_ready), the branch pc_sel (uses the flags), and the MEM-state retire for SD (uses dmem_ready).

## Timing

- Reset (async, rst_n=0): state=IDLE, latched fields=0, instret=0, erro=0, all outputs 0.
- Deasserting rst_n leads to FETCH on the next clock.
- Zero-wait memory (ready in the same cycle as req), cycles from entering FETCH to re-entering FETCH:
  - branch 3
  - ADD/SUB/ADDI 4
  - SD 4
  - LD 5
- Each wait cycle on imem_ready or dmem_ready adds exactly 1 cycle.
- Exactly one load_pc pulse per retired instruction, in the instruction's last cycle.
- Reset mid-instruction: the instruction is abandoned immediately, with no partial write or load_pc afterwards.
- imem_ready/dmem_ready outside FETCH/MEM are ignored.

## Structure

- Package unidade_controle_pkg holds:
  - the state enum;
  - opcode constants OP_R, OP_I, OP_LD, OP_SD, OP_B;
  - funct3/funct7 constants.
- One sub-module, decodificador_desvio: combinational mapping of funct3 and the three flags to taken.

## Test plan

- Reset, then ADD (0x00208133) with zero-wait memory:
  - FETCH, DECODE, EXEC, WB;
  - soma_ou_subtrai=1, subtraindo=0 in EXEC;
  - reg_write=1, wb_sel=0 in WB;
  - instret=1.
- SUB (funct7=0100000): subtraindo=1 in EXEC and WB.
- LD with imem_ready delayed 2 cycles and dmem_ready delayed 3 cycles:
  - total 10 cycles;
  - imediato=1 through MEM;
  - wb_sel=1, reg_write=1 in WB.
- BEQ and BNE:
  - BEQ with flag_igual=1: load_pc=1, pc_sel=1 in EXEC.
  - BNE with flag_igual=1: pc_sel=0.
  - BLTU with maior_u=0, igual=0: taken.
  - BGEU with maior_u=0, igual=0: not taken.
  - Each branch is 3 cycles, reg_write never 1.
- Illegal opcode 0x0000007F:
  - ERRO after DECODE, erro=1;
  - outputs stay 0 for 20 cycles;
  - rst_n pulse returns to IDLE with erro=0.
- rst_n asserted in MEM of SD: dmem_req drops asynchronously, no load_pc, instret unchanged at 0.
